// File: rtl/ahbl_pkg.sv
// ----------------------------------------------------------------------------
// ahbl_pkg
// Shared AHB-Lite encodings and the DMA copy engine state type.
//   HTRANS_*   : transfer-type encodings (only IDLE and NONSEQ are driven)
//   HSIZE_*    : transfer-size encodings
//   dma_state_t: address-phase state of the copy engine
//   word_align : clears the byte-offset bits of an address
//   next_word  : advances a word pointer, wrapping modulo 2^32
// ----------------------------------------------------------------------------
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Each state names the address phase currently on the bus.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_LAST = 3'd3,
    ST_FILL = 3'd4
  } dma_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] next_word(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/ahbl_mst_port.sv
// ----------------------------------------------------------------------------
// ahbl_mst_port
// Output register stage of an AHB-Lite master. The address/control phase is
// loaded only when the bus advances (adv = HREADY), so it is held through wait
// states. Write data is loaded one phase later and also held until accepted.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   adv                 bus advance (HREADY)
//   addr_nxt/trans_nxt/write_nxt  next address-phase values
//   wdata_ld/wdata_nxt  load strobe and value for the next write data phase
//   haddr/htrans/hsize/hwrite/hwdata  registered bus outputs
// ----------------------------------------------------------------------------
module ahbl_mst_port
  import ahbl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic [ADDR_W-1:0] addr_nxt,
  input  logic [1:0]        trans_nxt,
  input  logic              write_nxt,
  input  logic              wdata_ld,
  input  logic [DATA_W-1:0] wdata_nxt,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic              hwrite,
  output logic [DATA_W-1:0] hwdata
);

  logic [ADDR_W-1:0] addr_p0;
  logic [1:0]        trans_p0;
  logic              write_p0;
  logic [DATA_W-1:0] wdata_p1;

  // ---- stage p0: address / control phase ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p0  <= '0;
      trans_p0 <= HTRANS_IDLE;
      write_p0 <= 1'b0;
    end else if (adv) begin
      addr_p0  <= addr_nxt;
      trans_p0 <= trans_nxt;
      write_p0 <= write_nxt;
    end
  end

  // ---- stage p1: write data phase (doubles as the read buffer) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_p1 <= '0;
    end else if (adv && wdata_ld) begin
      wdata_p1 <= wdata_nxt;
    end
  end

  assign haddr  = addr_p0;
  assign htrans = trans_p0;
  assign hwrite = write_p0;
  assign hwdata = wdata_p1;
  assign hsize  = HSIZE_WORD;

endmodule

// File: rtl/ahbl_dma_copy.sv
// ----------------------------------------------------------------------------
// ahbl_dma_copy
// Single-channel AHB-Lite word-copy master. Copies len words from src to dst
// with the read of word i+1 overlapping the write data phase of word i, giving
// 2 cycles per word at zero wait states.
// Optional feature: define AHBL_DMA_FILL_EN to add fill_mode/fill_data ports;
// with fill_mode=1 the engine skips reads and writes fill_data to every word
// of the destination at 1 word per cycle.
// Ports:
//   HCLK, HRESETn       bus clock, asynchronous active-low reset
//   start/src/dst/len   program strobe and transfer descriptor
//   busy, done          transfer in progress, 1-cycle completion pulse
//   HADDR/HTRANS/HSIZE/HWRITE/HWDATA  AHB-Lite master outputs
//   HREADY, HRDATA      AHB-Lite ready and read data
//   fill_mode/fill_data (AHBL_DMA_FILL_EN only) fill request and pattern
// ----------------------------------------------------------------------------
module ahbl_dma_copy
  import ahbl_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic [2:0]       HSIZE,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic [31:0]      HRDATA
`ifdef AHBL_DMA_FILL_EN
  ,
  input  logic             fill_mode,
  input  logic [31:0]      fill_data
`endif
);

  dma_state_t       state, nxt_state;
  logic [31:0]      src_ptr, dst_ptr, nxt_src, nxt_dst;
  logic [LEN_W-1:0] remaining, nxt_rem;
  logic             nxt_busy, nxt_done;

  logic [31:0]      addr_nxt;
  logic [1:0]       trans_nxt;
  logic             write_nxt;
  logic             wdata_ld;
  logic [31:0]      wdata_nxt;

  logic             fill_req;
  logic [31:0]      fill_word;
  logic             accept_start;

  assign accept_start = HREADY && (state == ST_IDLE) && start && (len != '0);

`ifdef AHBL_DMA_FILL_EN
  logic [31:0] fill_data_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fill_data_q <= '0;
    end else if (accept_start) begin
      fill_data_q <= fill_data;
    end
  end

  // fill_mode is only consulted on the accepting cycle; the choice is then
  // remembered by the engine sitting in ST_FILL.
  assign fill_req  = fill_mode;
  assign fill_word = fill_data_q;
`else
  assign fill_req  = 1'b0;
  assign fill_word = '0;
`endif

  // The engine only steps when the bus advances; with HREADY low every
  // register below keeps its value, and the port holds the bus outputs.
  always_comb begin
    nxt_state = state;
    nxt_src   = src_ptr;
    nxt_dst   = dst_ptr;
    nxt_rem   = remaining;
    nxt_busy  = busy;
    nxt_done  = 1'b0;
    addr_nxt  = HADDR;
    trans_nxt = HTRANS_IDLE;
    write_nxt = HWRITE;
    wdata_ld  = 1'b0;
    wdata_nxt = HRDATA;

    if (HREADY) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len != '0) begin
              nxt_src   = word_align(src);
              nxt_dst   = word_align(dst);
              nxt_rem   = len;
              nxt_busy  = 1'b1;
              trans_nxt = HTRANS_NONSEQ;
              if (fill_req) begin
                nxt_state = ST_FILL;
                addr_nxt  = word_align(dst);
                write_nxt = 1'b1;
              end else begin
                nxt_state = ST_RD;
                addr_nxt  = word_align(src);
                write_nxt = 1'b0;
              end
            end else begin
              nxt_done = 1'b1;
            end
          end
        end

        ST_RD: begin
          nxt_state = ST_WR;
          nxt_src   = next_word(src_ptr);
          addr_nxt  = dst_ptr;
          trans_nxt = HTRANS_NONSEQ;
          write_nxt = 1'b1;
        end

        // Write address accepted: the read data phase ends on this same
        // edge, so HRDATA goes straight into the write data register.
        ST_WR: begin
          nxt_dst   = next_word(dst_ptr);
          nxt_rem   = remaining - LEN_W'(1);
          wdata_ld  = 1'b1;
          wdata_nxt = HRDATA;
          if (remaining > LEN_W'(1)) begin
            nxt_state = ST_RD;
            addr_nxt  = src_ptr;
            trans_nxt = HTRANS_NONSEQ;
            write_nxt = 1'b0;
          end else begin
            nxt_state = ST_LAST;
          end
        end

        ST_FILL: begin
          nxt_dst   = next_word(dst_ptr);
          nxt_rem   = remaining - LEN_W'(1);
          wdata_ld  = 1'b1;
          wdata_nxt = fill_word;
          if (remaining > LEN_W'(1)) begin
            addr_nxt  = next_word(dst_ptr);
            trans_nxt = HTRANS_NONSEQ;
            write_nxt = 1'b1;
          end else begin
            nxt_state = ST_LAST;
          end
        end

        ST_LAST: begin
          nxt_state = ST_IDLE;
          nxt_busy  = 1'b0;
          nxt_done  = 1'b1;
        end

        default: begin
          nxt_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      src_ptr   <= nxt_src;
      dst_ptr   <= nxt_dst;
      remaining <= nxt_rem;
      busy      <= nxt_busy;
      done      <= nxt_done;
    end
  end

  ahbl_mst_port #(
    .ADDR_W(32),
    .DATA_W(32)
  ) u_port (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .adv      (HREADY),
    .addr_nxt (addr_nxt),
    .trans_nxt(trans_nxt),
    .write_nxt(write_nxt),
    .wdata_ld (wdata_ld),
    .wdata_nxt(wdata_nxt),
    .haddr    (HADDR),
    .htrans   (HTRANS),
    .hsize    (HSIZE),
    .hwrite   (HWRITE),
    .hwdata   (HWDATA)
  );

endmodule
